countdown_timer_core: RTL and testbench
=======================================

// Module: countdown_timer_core
// PURPOSE
//  Parametrised mm:ss countdown timer with load, start, pause, clear and an alarm-flash phase.
//  Holds BCD minutes and seconds, decrements once per second and flashes an LED bank on expiry.
//  Sits between the debounced key/switch inputs and the 7-segment decoders and LEDs of the board top level.
// PARAMETERS
//  CLK_HZ       50_000_000  clock cycles per 1 s tick; must be >= 2
//  FLASH_HALF   12_500_000  cycles per flash half-period (ON phase and OFF phase each)
//  FLASH_COUNT  5           number of ON phases before returning to IDLE; must be >= 1
//  LED_W        10          alarm LED bank width
// PORTS
//  CLOCK_50   in   1      system clock, rising edge
//  RESET      in   1      asynchronous, active-high reset
//  clear      in   1      level; abort to IDLE and zero the time
//  start      in   1      single-cycle pulse; start or resume the countdown
//  pause      in   1      single-cycle pulse; hold the countdown
//  load_min   in   1      single-cycle pulse; min_bcd <= value
//  load_sec   in   1      single-cycle pulse; sec_bcd <= value
//  value      in   8      BCD {tens,units} load data
//  min_bcd    out  8      BCD minutes, 00..99
//  sec_bcd    out  8      BCD seconds, 00..59
//  state      out  3      current FSM state (package encoding)
//  alarm_led  out  LED_W  all ones in FLASH_ON, zero otherwise
//  done       out  1      one-cycle pulse on the cycle FLASH_ON is entered
// BEHAVIOUR
//  All outputs are registered. An input sampled at edge N is visible after edge N.
//  Reset values: min_bcd=00, sec_bcd=00, state=IDLE, alarm_led=0, done=0, prescaler=0, flash counters=0.
//  States: IDLE=0, READY=1, RUN=2, PAUSE=3, FLASH_ON=4, FLASH_OFF=5.
//  Input priority in the same cycle: clear > pause > start > load_min/load_sec. A lower-priority input is dropped, not queued.
//  clear: from any state go to IDLE. Zero the time, prescaler and flash counters. Set alarm_led=0.
//  Loads are accepted only in IDLE and READY.
//   - A nibble above 9 is clamped to 9.
//   - Seconds tens above 5 is clamped to 5.
//   - load_min and load_sec together are both applied.
//   - After a load the state is READY if the resulting time is non-zero, otherwise IDLE.
//  start:
//   - READY with non-zero time -> RUN, prescaler cleared.
//   - PAUSE -> RUN, prescaler kept.
//   - Ignored in every other state.
//  pause: RUN -> PAUSE, prescaler frozen. Ignored elsewhere.
//  RUN: the prescaler counts 0..CLK_HZ-1. At the wrap the time decrements once in BCD:
//   - sec units 0 borrows from sec tens.
//   - sec 00 becomes 59 and borrows a minute.
//   - min units 0 borrows from min tens.
//  First decrement: exactly CLK_HZ cycles after the start edge.
//  When a decrement produces 00:00, go to FLASH_ON on that same edge. done=1 for that one cycle.
//  FLASH_ON/FLASH_OFF: alternate every FLASH_HALF cycles. After the FLASH_COUNT-th ON phase, FLASH_OFF lasts FLASH_HALF cycles, then IDLE.
//  The time stays 00:00 throughout the flash phase. start, pause and loads are ignored during flash; only clear aborts it.
//  No decrement below 00:00 and no wrap from 00:00 to 99:59.
//  RESET asserted mid-run or mid-flash forces the reset values asynchronously.
// STRUCTURE
//  Shared package timer_pkg: state encodings (ST_IDLE..ST_FLASH_OFF), BCD clamp function, width constants.
//  Sub-module bcd_mmss_dec: combinational 16-bit BCD mm:ss decrement-by-one, with a zero flag.
//  The prescaler and flash counters are sized with $clog2 of CLK_HZ and FLASH_HALF.
// TESTING  (CLK_HZ=4, FLASH_HALF=2, FLASH_COUNT=2)
//  1. Load and start 00:02 -> 00:01 4 cycles after start, 00:00 4 cycles later; done pulses once; state=4.
//  2. Flash phase -> alarm_led pattern ON2, OFF2, ON2, OFF2 cycles, then state=IDLE and alarm_led=0.
//  3. Load min=10, sec=00 and run 1 tick -> 09:59.
//     Load value=8'hAF into sec -> sec_bcd=59.
//     Load value=8'h00 into both -> state stays IDLE.
//  4. Pause after 2 RUN cycles and hold 10 cycles -> no change; start -> decrement 2 cycles later (prescaler kept).
//  5. start+pause together in RUN -> PAUSE.
//     clear+start in READY -> IDLE, time 00:00.
//     load during RUN -> ignored.
//  6. Assert RESET mid-flash -> all outputs at reset values immediately; start after release is ignored (IDLE).

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the mm:ss countdown timer: state encodings, widths and
// the BCD load-value clamp.
package timer_pkg;

  localparam int BCD_W   = 8;
  localparam int TIME_W  = 2 * BCD_W;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_READY     = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSE     = 3'd3;
  localparam logic [STATE_W-1:0] ST_FLASH_ON  = 3'd4;
  localparam logic [STATE_W-1:0] ST_FLASH_OFF = 3'd5;

  // Saturate each nibble of a BCD pair: units at 9, tens at max_tens.
  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] v,
                                                 input logic [3:0]       max_tens);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (v[7:4] > max_tens) ? max_tens : v[7:4];
    units = (v[3:0] > 4'd9)     ? 4'd9     : v[3:0];
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational BCD mm:ss decrement-by-one; saturates at 00:00 and flags a
// zero result.
module bcd_mmss_dec
  import timer_pkg::*;
(
  input  logic [TIME_W-1:0] mmss_i,
  output logic [TIME_W-1:0] mmss_o,
  output logic              zero_o
);

  logic [3:0] min_t, min_u, sec_t, sec_u;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    {min_t, min_u, sec_t, sec_u} = mmss_i;
    if (mmss_i == '0) begin
      {min_t, min_u, sec_t, sec_u} = '0;
    end else if (sec_u != 4'd0) begin
      sec_u = sec_u - 4'd1;
    end else if (sec_t != 4'd0) begin
      sec_t = sec_t - 4'd1;
      sec_u = 4'd9;
    end else begin
      // ss == 00 with a non-zero total: borrow a minute.
      sec_t = 4'd5;
      sec_u = 4'd9;
      if (min_u != 4'd0) begin
        min_u = min_u - 4'd1;
      end else begin
        min_u = 4'd9;
        min_t = min_t - 4'd1;
      end
    end
    mmss_o = {min_t, min_u, sec_t, sec_u};
    zero_o = (mmss_o == '0);
  end

endmodule

// File: rtl/countdown_timer_core.sv
// mm:ss countdown timer: load, start, pause, clear, once-per-second BCD
// decrement and an alarm-flash phase on expiry. All outputs are registered.
module countdown_timer_core
  import timer_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int FLASH_HALF  = 12_500_000,
  parameter int FLASH_COUNT = 5,
  parameter int LED_W       = 10
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               clear,
  input  logic               start,
  input  logic               pause,
  input  logic               load_min,
  input  logic               load_sec,
  input  logic [BCD_W-1:0]   value,
  output logic [BCD_W-1:0]   min_bcd,
  output logic [BCD_W-1:0]   sec_bcd,
  output logic [STATE_W-1:0] state,
  output logic [LED_W-1:0]   alarm_led,
  output logic               done
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int FL_W  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int PH_W  = $clog2(FLASH_COUNT + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLASH_HALF - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(FLASH_COUNT);

  logic [STATE_W-1:0] state_q, state_d;
  logic [BCD_W-1:0]   min_q, min_d;
  logic [BCD_W-1:0]   sec_q, sec_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [FL_W-1:0]    fl_cnt_q, fl_cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [LED_W-1:0]   alarm_q, alarm_d;
  logic               done_q, done_d;

  logic [TIME_W-1:0]  dec_time;
  logic               dec_zero;
  logic [BCD_W-1:0]   new_min, new_sec;

  bcd_mmss_dec u_dec (
    .mmss_i (({min_q, sec_q})),
    .mmss_o (dec_time),
    .zero_o (dec_zero)
  );

  assign new_min = load_min ? clamp_bcd(value, 4'd9) : min_q;
  assign new_sec = load_sec ? clamp_bcd(value, 4'd5) : sec_q;

  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    pre_d    = pre_q;
    fl_cnt_d = fl_cnt_q;
    phase_d  = phase_q;
    done_d   = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      min_d    = '0;
      sec_d    = '0;
      pre_d    = '0;
      fl_cnt_d = '0;
      phase_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_READY: begin
          // A pause here has no effect but still outranks start and loads.
          if (pause) begin
            state_d = state_q;
          end else if (start) begin
            if (state_q == ST_READY && {min_q, sec_q} != '0) begin
              state_d = ST_RUN;
              pre_d   = '0;
            end
          end else if (load_min || load_sec) begin
            min_d   = new_min;
            sec_d   = new_sec;
            state_d = ({new_min, new_sec} != '0) ? ST_READY : ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (pre_q == PRE_LAST) begin
            pre_d          = '0;
            {min_d, sec_d} = dec_time;
            if (dec_zero) begin
              state_d  = ST_FLASH_ON;
              fl_cnt_d = '0;
              phase_d  = '0;
              done_d   = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        ST_FLASH_ON: begin
          if (fl_cnt_q == FL_LAST) begin
            fl_cnt_d = '0;
            phase_d  = phase_q + 1'b1;
            state_d  = ST_FLASH_OFF;
          end else begin
            fl_cnt_d = fl_cnt_q + 1'b1;
          end
        end
        ST_FLASH_OFF: begin
          if (fl_cnt_q == FL_LAST) begin
            fl_cnt_d = '0;
            if (phase_q == PH_LAST) begin
              state_d = ST_IDLE;
              phase_d = '0;
            end else begin
              state_d = ST_FLASH_ON;
            end
          end else begin
            fl_cnt_d = fl_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    alarm_d = (state_d == ST_FLASH_ON) ? {LED_W{1'b1}} : '0;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      min_q    <= '0;
      sec_q    <= '0;
      pre_q    <= '0;
      fl_cnt_q <= '0;
      phase_q  <= '0;
      alarm_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q  <= state_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      pre_q    <= pre_d;
      fl_cnt_q <= fl_cnt_d;
      phase_q  <= phase_d;
      alarm_q  <= alarm_d;
      done_q   <= done_d;
    end
  end

  assign min_bcd   = min_q;
  assign sec_bcd   = sec_q;
  assign state     = state_q;
  assign alarm_led = alarm_q;
  assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed and randomized bench for countdown_timer_core against a model that
// tracks the remaining time as plain seconds and the flash as elapsed cycles.
module tb_countdown_timer_core;

  localparam int CLK_HZ      = 4;
  localparam int FLASH_HALF  = 2;
  localparam int FLASH_COUNT = 2;
  localparam int LED_W       = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0, start = 1'b0, pause = 1'b0;
  logic             load_min = 1'b0, load_sec = 1'b0;
  logic [7:0]       value = 8'h00;
  logic [7:0]       min_bcd, sec_bcd;
  logic [2:0]       state;
  logic [LED_W-1:0] alarm_led;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  // Reference model: 0 idle, 1 ready, 2 run, 3 pause, 4 flash on, 5 flash off.
  int   m_state, m_secs, m_elapsed, m_flash_t;
  logic m_done;

  always #5 clk = ~clk;

  countdown_timer_core #(
    .CLK_HZ      (CLK_HZ),
    .FLASH_HALF  (FLASH_HALF),
    .FLASH_COUNT (FLASH_COUNT),
    .LED_W       (LED_W)
  ) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .clear     (clear),
    .start     (start),
    .pause     (pause),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .value     (value),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .state     (state),
    .alarm_led (alarm_led),
    .done      (done)
  );

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  function automatic int clamp_dec(input logic [7:0] v, input int max_t);
    int t, u;
    t = (int'(v[7:4]) > max_t) ? max_t : int'(v[7:4]);
    u = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
    return t * 10 + u;
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_elapsed = 0; m_flash_t = 0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic c, s, p, lm, ls, input logic [7:0] v);
    int mins, ss;
    m_done = 1'b0;
    if (c) begin
      m_state = 0; m_secs = 0; m_elapsed = 0; m_flash_t = 0;
    end else begin
      case (m_state)
        0, 1: begin
          if (p) begin
            // dropped
          end else if (s) begin
            if (m_state == 1 && m_secs > 0) begin
              m_state = 2; m_elapsed = 0;
            end
          end else if (lm || ls) begin
            mins = m_secs / 60;
            ss   = m_secs % 60;
            if (lm) mins = clamp_dec(v, 9);
            if (ls) ss   = clamp_dec(v, 5);
            m_secs  = mins * 60 + ss;
            m_state = (m_secs > 0) ? 1 : 0;
          end
        end
        2: begin
          if (p) begin
            m_state = 3;
          end else begin
            m_elapsed++;
            if (m_elapsed == CLK_HZ) begin
              m_elapsed = 0;
              m_secs--;
              if (m_secs == 0) begin
                m_state = 4; m_flash_t = 0; m_done = 1'b1;
              end
            end
          end
        end
        3: if (s) m_state = 2;
        default: begin
          m_flash_t++;
          if (m_flash_t == 2 * FLASH_COUNT * FLASH_HALF) m_state = 0;
          else m_state = ((m_flash_t / FLASH_HALF) % 2 == 0) ? 4 : 5;
        end
      endcase
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [LED_W-1:0] exp_led;
    exp_led = (m_state == 4) ? {LED_W{1'b1}} : '0;
    check_eq({tag, ".min"},   32'(min_bcd),   32'(to_bcd(m_secs / 60)));
    check_eq({tag, ".sec"},   32'(sec_bcd),   32'(to_bcd(m_secs % 60)));
    check_eq({tag, ".state"}, 32'(state),     32'(m_state));
    check_eq({tag, ".led"},   32'(alarm_led), 32'(exp_led));
    check_eq({tag, ".done"},  32'(done),      32'(m_done));
  endtask

  task automatic step(input logic c, s, p, lm, ls, input logic [7:0] v, input string tag);
    clear = c; start = s; pause = p; load_min = lm; load_sec = ls; value = v;
    @(posedge clk);
    model_step(c, s, p, lm, ls, v);
    #1;
    clear = 1'b0; start = 1'b0; pause = 1'b0; load_min = 1'b0; load_sec = 1'b0;
    check_all(tag);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00, tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // 1/2: 00:02 expiry and the full flash pattern back to IDLE.
    done_seen = 0;
    step(0, 0, 0, 0, 1, 8'h02, "t1_load");
    step(0, 1, 0, 0, 0, 8'h00, "t1_start");
    idle(8, "t1_run");
    idle(8, "t2_flash");
    check_eq("t2_done_count", 32'(done_seen), 32'd1);
    idle(1, "t2_idle");

    // 3: minute borrow, clamping, zero load.
    step(0, 0, 0, 1, 0, 8'h10, "t3_ldmin");
    step(0, 0, 0, 0, 1, 8'h00, "t3_ldsec");
    step(0, 1, 0, 0, 0, 8'h00, "t3_start");
    idle(4, "t3_tick");
    step(1, 0, 0, 0, 0, 8'h00, "t3_clear");
    step(0, 0, 0, 0, 1, 8'hAF, "t3_clamp");
    step(0, 0, 0, 1, 1, 8'h00, "t3_zero");

    // 4: pause holds the prescaler across a resume.
    step(0, 0, 0, 0, 1, 8'h05, "t4_load");
    step(0, 1, 0, 0, 0, 8'h00, "t4_start");
    idle(2, "t4_run");
    step(0, 0, 1, 0, 0, 8'h00, "t4_pause");
    idle(10, "t4_hold");
    step(0, 1, 0, 0, 0, 8'h00, "t4_resume");
    idle(2, "t4_dec");

    // 5: priority and ignored inputs.
    step(0, 1, 1, 0, 0, 8'h00, "t5_start_pause");
    step(1, 0, 0, 0, 0, 8'h00, "t5_clear");
    step(0, 0, 0, 0, 1, 8'h03, "t5_load");
    step(1, 1, 0, 0, 0, 8'h00, "t5_clear_start");
    step(0, 1, 0, 0, 0, 8'h00, "t5_start_idle");
    step(0, 0, 0, 0, 1, 8'h03, "t5_load2");
    step(0, 0, 1, 0, 1, 8'h07, "t5_pause_load");
    step(0, 1, 0, 0, 0, 8'h00, "t5_start");
    step(0, 0, 0, 0, 1, 8'h09, "t5_load_run");
    step(0, 1, 0, 0, 0, 8'h00, "t5_start_run");
    idle(3, "t5_run");

    // 6: asynchronous reset mid-flash.
    step(1, 0, 0, 0, 0, 8'h00, "t6_clear");
    step(0, 0, 0, 0, 1, 8'h01, "t6_load");
    step(0, 1, 0, 0, 0, 8'h00, "t6_start");
    idle(4, "t6_expire");
    idle(3, "t6_flash");
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6_async_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 1, 0, 0, 0, 8'h00, "t6_start_after");

    // Randomized traffic, at most one command per cycle.
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [7:0] v;
      r = int'($urandom_range(0, 99));
      v = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 3));
      if      (r < 2)  step(1, 0, 0, 0, 0, v, "rnd_clear");
      else if (r < 10) step(0, 1, 0, 0, 0, v, "rnd_start");
      else if (r < 13) step(0, 0, 1, 0, 0, v, "rnd_pause");
      else if (r < 21) step(0, 0, 0, 1, 0, v, "rnd_ldmin");
      else if (r < 31) step(0, 0, 0, 0, 1, v, "rnd_ldsec");
      else if (r < 34) step(0, 0, 0, 1, 1, v, "rnd_ldboth");
      else             step(0, 0, 0, 0, 0, v, "rnd_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
